// File: rtl/id_ex_skid.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_skid
// Description : ID/EX pipeline register with a one-entry skid buffer, flush,
//               sticky immediate sign-extension check and stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_skid #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_rd,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [DATA_W-1:0] in_imm_ext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [3:0]        out_rd,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic [DATA_W-1:0] out_imm_ext,
    input  logic              flush,
    output logic              ext_err,
    output logic [7:0]        stall_cnt
);

    localparam int c_PAY_W = 8 + 3 * DATA_W;

    logic               r_mainValid;
    logic               r_skidValid;
    logic               r_inReady;
    logic               r_extErr;
    logic [7:0]         r_stallCnt;
    logic [c_PAY_W-1:0] r_mainPay;
    logic [c_PAY_W-1:0] r_skidPay;

    logic               w_accept;
    logic               w_handoff;
    logic [c_PAY_W-1:0] w_inPay;
    logic [DATA_W-1:0]  w_immSext;

    assign w_accept  = in_valid & r_inReady;
    assign w_handoff = r_mainValid & out_ready;
    assign w_inPay   = {in_op, in_rd, in_rs_val, in_rt_val, in_imm_ext};
    assign w_immSext = {{(DATA_W - IMM_W){in_imm[IMM_W-1]}}, in_imm};

    // While the skid entry is full in_ready is low, so no accept can coincide
    // with a skid-to-main move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
            r_mainPay   <= '0;
            r_skidPay   <= '0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else if (w_handoff && r_skidValid) begin
            r_mainPay   <= r_skidPay;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else if (w_accept && (!r_mainValid || w_handoff)) begin
            r_mainPay   <= w_inPay;
            r_mainValid <= 1'b1;
        end else if (w_accept) begin
            r_skidPay   <= w_inPay;
            r_skidValid <= 1'b1;
            r_inReady   <= 1'b0;
        end else if (w_handoff) begin
            r_mainValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_extErr <= 1'b0;
        end else if (w_accept && (in_imm_ext != w_immSext)) begin
            r_extErr <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= 8'h00;
        end else if (r_mainValid && !out_ready && (r_stallCnt != 8'hFF)) begin
            r_stallCnt <= r_stallCnt + 8'd1;
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_mainValid;
    assign out_op      = r_mainPay[3*DATA_W+7 : 3*DATA_W+4];
    assign out_rd      = r_mainPay[3*DATA_W+3 : 3*DATA_W];
    assign out_rs_val  = r_mainPay[3*DATA_W-1 : 2*DATA_W];
    assign out_rt_val  = r_mainPay[2*DATA_W-1 : DATA_W];
    assign out_imm_ext = r_mainPay[DATA_W-1 : 0];
    assign ext_err     = r_extErr;
    assign stall_cnt   = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_skid
// Description : Scoreboard bench for id_ex_skid with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_skid;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] immExt;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [3:0]  in_rd = '0;
    logic [15:0] in_rs_val = '0;
    logic [15:0] in_rt_val = '0;
    logic [7:0]  in_imm = '0;
    logic [15:0] in_imm_ext = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_op;
    logic [3:0]  out_rd;
    logic [15:0] out_rs_val;
    logic [15:0] out_rt_val;
    logic [15:0] out_imm_ext;
    logic        flush = 1'b0;
    logic        ext_err;
    logic [7:0]  stall_cnt;

    id_ex_skid #(.DATA_W(16), .IMM_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_imm(in_imm), .in_imm_ext(in_imm_ext),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_rs_val(out_rs_val),
        .out_rt_val(out_rt_val), .out_imm_ext(out_imm_ext),
        .flush(flush), .ext_err(ext_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: occupancy, pending payloads in FIFO order, sticky flag, stall count.
    int   occ = 0;
    pay_t sbq[$];
    bit   mExt = 1'b0;
    int   mStall = 0;
    int   nChecks = 0;
    int   nPass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] sext(input logic [7:0] i);
        return (i >= 8'h80) ? (16'(i) + 16'hFF00) : 16'(i);
    endfunction

    function automatic pay_t mk(input logic [15:0] ext);
        pay_t p;
        p.op     = 4'($urandom);
        p.rd     = 4'($urandom);
        p.rs     = 16'($urandom);
        p.rt     = 16'($urandom);
        p.immExt = ext;
        return p;
    endfunction

    // Monitor: compares DUT state and presented payload against the model.
    always @(negedge clk) begin
        chk("out_valid", out_valid, 64'(occ > 0));
        chk("in_ready", in_ready, 64'(occ < 2));
        chk("ext_err", ext_err, 64'(mExt));
        chk("stall_cnt", stall_cnt, 64'(mStall));
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                chk("payload", 64'({out_op, out_rd, out_rs_val, out_rt_val, out_imm_ext}),
                    64'(sbq[0]));
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic drive(input bit iv, input bit ordy, input bit fl,
                         input logic [7:0] imm, input pay_t p);
        bit acc;
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        in_imm     = imm;
        in_op      = p.op;
        in_rd      = p.rd;
        in_rs_val  = p.rs;
        in_rt_val  = p.rt;
        in_imm_ext = p.immExt;
        acc = iv && (occ < 2);
        if (acc && !fl) sbq.push_back(p);
        @(posedge clk);
        if (acc && (p.immExt != sext(imm))) mExt = 1'b1;
        if ((occ > 0) && !ordy && (mStall < 255)) mStall++;
        if (fl) begin
            occ = 0;
            sbq.delete();
        end else begin
            occ = occ - int'((occ > 0) && ordy) + int'(acc);
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        drive(1'b0, ordy, 1'b0, 8'h00, mk(16'h0000));
    endtask

    task automatic send(input bit ordy, input logic [7:0] imm, input logic [15:0] ext);
        drive(1'b1, ordy, 1'b0, imm, mk(ext));
    endtask

    // Asynchronous pulse placed between edges; outputs must clear before any edge.
    task automatic pulseReset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 64'd0);
        chk("rst_in_ready", in_ready, 64'd1);
        chk("rst_stall_cnt", stall_cnt, 64'd0);
        chk("rst_ext_err", ext_err, 64'd0);
        chk("rst_payload", 64'({out_op, out_rd, out_rs_val, out_rt_val, out_imm_ext}), 64'd0);
        occ = 0;
        sbq.delete();
        mExt = 1'b0;
        mStall = 0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] streamImm [8] = '{8'h00, 8'h01, 8'h12, 8'h43, 8'h11, 8'h17, 8'hA9, 8'h8F};
        #23 rst_n = 1'b1;

        // Streaming with out_ready held high.
        foreach (streamImm[i]) send(1'b1, streamImm[i], sext(streamImm[i]));
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: A then B, then release.
        send(1'b0, 8'h05, 16'h0005);
        send(1'b0, 8'hF0, 16'hFFF0);
        idle(1'b0);
        repeat (3) idle(1'b1);

        // Flush with both entries full and a coinciding input.
        send(1'b0, 8'h21, 16'h0021);
        send(1'b0, 8'h22, 16'h0022);
        drive(1'b1, 1'b0, 1'b1, 8'h33, mk(16'h0033));
        repeat (3) idle(1'b1);

        // Sign-extension mismatch, sticky through flush.
        send(1'b1, 8'h8F, 16'h008F);
        idle(1'b1);
        chk("ext_err_set", ext_err, 64'd1);
        send(1'b0, 8'h01, 16'h0001);
        drive(1'b0, 1'b0, 1'b1, 8'h00, mk(16'h0000));
        idle(1'b1);
        chk("ext_err_sticky", ext_err, 64'd1);
        pulseReset();
        send(1'b1, 8'h8F, 16'hFF8F);
        idle(1'b1);
        chk("ext_err_clean", ext_err, 64'd0);

        // Stall saturation.
        send(1'b0, 8'h10, 16'h0010);
        repeat (300) idle(1'b0);
        chk("stall_sat", stall_cnt, 64'hFF);
        repeat (2) idle(1'b1);
        chk("stall_hold", stall_cnt, 64'hFF);

        // Asynchronous reset with both entries full.
        send(1'b0, 8'h44, 16'h0044);
        send(1'b0, 8'h45, 16'h0045);
        pulseReset();
        send(1'b1, 8'h46, 16'h0046);
        idle(1'b1);

        // Randomized traffic, correct immediates with rare flushes.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] imm;
            imm = 8'($urandom);
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 99) < 3), imm, mk(sext(imm)));
        end
        // Randomized traffic with occasional corrupt extensions.
        for (int i = 0; i < 500; i++) begin
            logic [7:0] imm;
            imm = 8'($urandom);
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6), 1'b0, imm,
                  mk(($urandom_range(0, 19) == 0) ? 16'($urandom) : sext(imm)));
        end
        repeat (4) idle(1'b1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_skid.md
ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, register-operand and extended-immediate width.
REQ-002 The module SHALL have parameter IMM_W, default 8, raw immediate width, with IMM_W < DATA_W.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid  input  1  decode stage presents a payload.
REQ-006 The module SHALL have port in_ready  output  1  stage can accept a payload this cycle.
REQ-007 The module SHALL have port in_op  input  4  opcode.
REQ-008 The module SHALL have port in_rd  input  4  destination register index.
REQ-009 The module SHALL have port in_rs_val  input  DATA_W  source operand A.
REQ-010 The module SHALL have port in_rt_val  input  DATA_W  source operand B.
REQ-011 The module SHALL have port in_imm  input  IMM_W  raw immediate from the instruction.
REQ-012 The module SHALL have port in_imm_ext  input  DATA_W  immediate from the upstream sign-extender.
REQ-013 The module SHALL have port out_valid  output  1  execute-side payload valid.
REQ-014 The module SHALL have port out_ready  input  1  execute stage accepts the payload.
REQ-015 The module SHALL have ports out_op, out_rd, out_rs_val, out_rt_val and out_imm_ext  output, with the same widths as their in_ counterparts  registered payload; the raw immediate SHALL NOT be forwarded.
REQ-016 The module SHALL have port flush  input  1  discard all held payloads (branch taken).
REQ-017 The module SHALL have port ext_err  output  1  sticky flag: an accepted in_imm_ext disagreed with in_imm.
REQ-018 The module SHALL have port stall_cnt  output  8  saturating count of back-pressure cycles.

Function
REQ-019 The module SHALL hold a main entry, which drives the out_ ports, and one skid entry; each entry SHALL carry its own valid bit.
REQ-020 in_ready SHALL be a registered signal, equal to NOT skid_valid; it SHALL have no combinational path from out_ready.
REQ-021 An accept SHALL occur when in_valid and in_ready are both high; a handoff SHALL occur when out_valid and out_ready are both high.
REQ-022 On accept with the main entry empty, or with a handoff in the same cycle and the skid entry empty, the payload SHALL load into the main entry; latency SHALL be 1 cycle, in to out.
REQ-023 On accept with the main entry full and no handoff, the payload SHALL load into the skid entry, and in_ready SHALL fall on the next cycle.
REQ-024 On handoff with the skid entry full, the skid entry SHALL move to the main entry and the skid entry SHALL be cleared; ordering SHALL be strictly FIFO.
REQ-025 When out_valid is high and out_ready is low, the out_ payload SHALL remain stable until handoff.
REQ-026 A flush SHALL clear both valid bits on the next edge and SHALL take priority over a same-cycle accept, which is dropped; in_ready SHALL be 1 on the cycle after the flush.
REQ-027 On each accept, the module SHALL compare in_imm_ext against the sign extension of in_imm (bit IMM_W-1 replicated into the upper bits); a mismatch SHALL set ext_err on the next edge.
REQ-028 ext_err SHALL clear only on reset; a flush SHALL NOT clear it.
REQ-029 stall_cnt SHALL increment on every cycle with out_valid high and out_ready low, SHALL saturate at 8'hFF, and SHALL NOT wrap.
REQ-030 out_valid SHALL equal main_valid exactly; the payload of invalid entries SHALL be don't-care but deterministic.

Reset
REQ-031 While rst_n is low, regardless of clk, the module SHALL force main_valid=0, skid_valid=0, in_ready=1, ext_err=0, stall_cnt=0 and all out_ payload bits to 0.
REQ-032 An rst_n assertion in the middle of a transfer SHALL discard both entries without producing a handoff; the first accept SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-033 The bench SHALL cover streaming: out_ready held at 1, payloads with imm=00,01,12,43,11,17,A9,8F and correct imm_ext -> each appears on out one cycle later, in order, with in_ready always 1, ext_err=0 and stall_cnt=0.
REQ-034 The bench SHALL cover back-pressure: with out_ready=0, accept A then B -> the cycle after B, in_ready=0 and out holds A; raising out_ready -> A then B are delivered, no loss and no duplicate.
REQ-035 The bench SHALL cover flush: with both entries full and flush=1 coinciding with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the input payload is never delivered.
REQ-036 The bench SHALL cover the sign-extension check: accept imm=8F with imm_ext=008F -> ext_err=1 next cycle and it stays 1 through a flush; imm=8F with imm_ext=FF8F (error-free case, after reset) -> ext_err=0.
REQ-037 The bench SHALL cover stall saturation: out_valid=1 with out_ready=0 for 300 cycles -> stall_cnt=FF and holds.
REQ-038 The bench SHALL cover asynchronous reset: rst_n pulsed low between clock edges while both entries are full -> out_valid=0, in_ready=1 and stall_cnt=0 immediately, before the next edge.
